axilite_master: RTL and testbench

- AXI-Lite initiator that converts single-beat backend write/read requests into AXI-Lite transactions.
- Drives the subset channel set used by axilite_slave: AW, W, AR, R, with no B channel and no response codes.
- Sits between the fabric-side request logic and any axilite_slave-compatible target.
- Adds a per-transaction timeout, so a hung target cannot stall the backend.

---
 rtl/axil_master_pkg.sv | 18 +
 rtl/axil_timeout_cnt.sv | 38 +++
 rtl/axilite_master.sv | 217 +++++++++++++++++++++
 tb/tb_axilite_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI-Lite initiator.
package axil_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 15;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    // Wide enough for any practical bus; sliced down to DATA_WIDTH by users.
    localparam int unsigned              TIMEOUT_RDATA_MAX_W = 1024;
    localparam logic [TIMEOUT_RDATA_MAX_W-1:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Per-state wait counter: expire fires in the TIMEOUT_CYCLES-th cycle spent in a state.
module axil_timeout_cnt
    import axil_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/axilite_master.sv
// AXI-Lite initiator: turns single-beat backend write/read strobes into AW/W/AR/R traffic with a per-state timeout.
module axilite_master
    import axil_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    cc_enable,
    input  logic                    bk_wstart,
    input  logic [ADDR_WIDTH-1:0]   bk_waddr,
    input  logic [DATA_WIDTH-1:0]   bk_wdata,
    input  logic [DATA_WIDTH/8-1:0] bk_wstrb,
    output logic                    bk_wdone,
    input  logic                    bk_rstart,
    input  logic [ADDR_WIDTH-1:0]   bk_raddr,
    output logic [DATA_WIDTH-1:0]   bk_rdata,
    output logic                    bk_rdone,
    output logic                    bk_err,
    output logic                    bk_busy,
    output logic                    axi_awvalid,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                    axi_awready,
    output logic                    axi_wvalid,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wready,
    output logic                    axi_arvalid,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                    axi_arready,
    input  logic                    axi_rvalid,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic                    axi_rready
);

    state_e                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    wdone_q, wdone_d, rdone_q, rdone_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    aw_hs, w_hs, aw_fin, w_fin, expire, tmo_clear;

    assign aw_hs  = awvalid_q & axi_awready;
    assign w_hs   = wvalid_q & axi_wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // Counter restarts whenever the state changes, so each wait phase gets a full budget.
    assign tmo_clear = (state_q == ST_IDLE) || (state_d != state_q);

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .clear (tmo_clear),
        .enable(state_q != ST_IDLE),
        .expire(expire)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        wdone_d   = 1'b0;
        rdone_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cc_enable && bk_wstart) begin
                    state_d   = ST_WRITE;
                    awaddr_d  = bk_waddr;
                    wdata_d   = bk_wdata;
                    wstrb_d   = bk_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (bk_rstart) begin
                        pend_d   = 1'b1;
                        araddr_d = bk_raddr;
                    end
                end else if (cc_enable && bk_rstart) begin
                    state_d   = ST_RD_ADDR;
                    araddr_d  = bk_raddr;
                    arvalid_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Completion wins over a timeout landing on the same edge.
                if (aw_fin && w_fin) begin
                    wdone_d = 1'b1;
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (expire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    pend_d    = 1'b0;
                    wdone_d   = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end else if (expire) begin
                    arvalid_d = 1'b0;
                    rdone_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = TIMEOUT_RDATA[DATA_WIDTH-1:0];
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = axi_rdata;
                    rdone_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expire) begin
                    rready_d = 1'b0;
                    rdone_d  = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = TIMEOUT_RDATA[DATA_WIDTH-1:0];
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            wdone_q   <= 1'b0;
            rdone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            wdone_q   <= wdone_d;
            rdone_q   <= rdone_d;
            err_q     <= err_d;
        end
    end

    assign bk_wdone    = wdone_q;
    assign bk_rdone    = rdone_q;
    assign bk_err      = err_q;
    assign bk_rdata    = rdata_q;
    assign bk_busy     = (state_q != ST_IDLE);
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = araddr_q;
    assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axilite_master.sv
// Randomized bench for axilite_master: a cycle-timeline model predicts every output, checked each cycle.
module tb_axilite_master;

    localparam int AW = 15, DW = 32, SW = 4, TO = 8, NCYC = 4096;
    localparam int S_AWV = 0, S_WV = 1, S_ARV = 2, S_RR = 3, S_WD = 4, S_RD = 5, S_ERR = 6, S_BUSY = 7;

    logic          clk = 1'b0, rst_n = 1'b0, cc_enable = 1'b0;
    logic          bk_wstart = 1'b0, bk_rstart = 1'b0;
    logic [AW-1:0] bk_waddr = '0, bk_raddr = '0;
    logic [DW-1:0] bk_wdata = '0;
    logic [SW-1:0] bk_wstrb = '0;
    logic          bk_wdone, bk_rdone, bk_err, bk_busy;
    logic [DW-1:0] bk_rdata;
    logic          axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0, axi_rvalid = 1'b0;
    logic [DW-1:0] axi_rdata = '0;

    axilite_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .cc_enable(cc_enable),
        .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_wdone(bk_wdone), .bk_rstart(bk_rstart), .bk_raddr(bk_raddr), .bk_rdata(bk_rdata),
        .bk_rdone(bk_rdone), .bk_err(bk_err), .bk_busy(bk_busy),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_wvalid(axi_wvalid),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_arvalid(axi_arvalid),
        .axi_araddr(axi_araddr), .axi_rready(axi_rready), .axi_awready(axi_awready),
        .axi_wready(axi_wready), .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
        .axi_rdata(axi_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    int last_wdone = -1, last_rdone = -1, last_err = -1;

    // Expected timeline, one entry per cycle.
    bit          ex [0:7][0:NCYC-1];
    logic [31:0] ex_rdata [0:NCYC-1];
    logic [31:0] ex_awaddr [0:NCYC-1];
    logic [31:0] ex_wdata [0:NCYC-1];
    logic [31:0] ex_wstrb [0:NCYC-1];
    logic [31:0] ex_araddr [0:NCYC-1];

    // Slave behaviour: ready/rvalid after a programmed number of valid cycles (255 = never).
    int sl_aw_d = 0, sl_w_d = 0, sl_ar_d = 0, sl_r_d = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [DW-1:0] sl_rdata = '0;

    always @(posedge clk) begin
        #3;
        if (axi_awvalid) begin axi_awready = (aw_cnt == sl_aw_d); aw_cnt++; end
        else begin axi_awready = 1'b0; aw_cnt = 0; end
        if (axi_wvalid) begin axi_wready = (w_cnt == sl_w_d); w_cnt++; end
        else begin axi_wready = 1'b0; w_cnt = 0; end
        if (axi_arvalid) begin axi_arready = (ar_cnt == sl_ar_d); ar_cnt++; end
        else begin axi_arready = 1'b0; ar_cnt = 0; end
        if (axi_rready) begin axi_rvalid = (r_cnt == sl_r_d); r_cnt++; end
        else begin axi_rvalid = 1'b0; r_cnt = 0; end
        axi_rdata = axi_rvalid ? sl_rdata : DW'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk("awvalid", 32'(axi_awvalid), 32'(ex[S_AWV][cyc]));
            chk("wvalid",  32'(axi_wvalid),  32'(ex[S_WV][cyc]));
            chk("arvalid", 32'(axi_arvalid), 32'(ex[S_ARV][cyc]));
            chk("rready",  32'(axi_rready),  32'(ex[S_RR][cyc]));
            chk("bk_wdone", 32'(bk_wdone), 32'(ex[S_WD][cyc]));
            chk("bk_rdone", 32'(bk_rdone), 32'(ex[S_RD][cyc]));
            chk("bk_err",   32'(bk_err),   32'(ex[S_ERR][cyc]));
            chk("bk_busy",  32'(bk_busy),  32'(ex[S_BUSY][cyc]));
            chk("bk_rdata", bk_rdata, ex_rdata[cyc]);
            if (ex[S_AWV][cyc]) chk("awaddr", 32'(axi_awaddr), ex_awaddr[cyc]);
            if (ex[S_WV][cyc]) begin
                chk("wdata", axi_wdata, ex_wdata[cyc]);
                chk("wstrb", 32'(axi_wstrb), ex_wstrb[cyc]);
            end
            if (ex[S_ARV][cyc]) chk("araddr", 32'(axi_araddr), ex_araddr[cyc]);
            if (bk_wdone) last_wdone = cyc;
            if (bk_rdone) last_rdone = cyc;
            if (bk_err)   last_err   = cyc;
        end
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic mark(input int sig, input int from, input int to);
        for (int c = from; c <= to; c++) if (c >= 0 && c < NCYC) ex[sig][c] = 1'b1;
    endtask

    task automatic rdata_from(input int from, input logic [31:0] v);
        for (int c = from; c < NCYC; c++) ex_rdata[c] = v;
    endtask

    // Write issued at cycle s: valids from s+1, each drops after its own handshake;
    // the state ends after both handshakes or after TO waiting cycles.
    task automatic plan_write(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] st, input int da, input int dw,
                              output int e, output bit ok);
        int m;
        m  = (da > dw) ? da : dw;
        ok = (m <= TO - 1);
        e  = s + 1 + imin(m, TO - 1);
        for (int c = s + 1; c <= s + 1 + imin(da, TO - 1); c++) begin
            ex[S_AWV][c] = 1'b1; ex_awaddr[c] = 32'(a);
        end
        for (int c = s + 1; c <= s + 1 + imin(dw, TO - 1); c++) begin
            ex[S_WV][c] = 1'b1; ex_wdata[c] = d; ex_wstrb[c] = 32'(st);
        end
        mark(S_BUSY, s + 1, e);
        mark(S_WD, e + 1, e + 1);
        if (!ok) mark(S_ERR, e + 1, e + 1);
    endtask

    // Read whose arvalid first appears in cycle a0.
    task automatic plan_read(input int a0, input logic [AW-1:0] a, input logic [DW-1:0] v,
                             input int da, input int dr, output int last);
        int r0;
        for (int c = a0; c <= a0 + imin(da, TO - 1); c++) begin
            ex[S_ARV][c] = 1'b1; ex_araddr[c] = 32'(a);
        end
        if (da > TO - 1) begin
            last = a0 + TO - 1;
            mark(S_ERR, last + 1, last + 1);
            rdata_from(last + 1, 32'hFFFF_FFFF);
        end else begin
            r0   = a0 + da + 1;
            last = r0 + imin(dr, TO - 1);
            mark(S_RR, r0, last);
            if (dr > TO - 1) begin
                mark(S_ERR, last + 1, last + 1);
                rdata_from(last + 1, 32'hFFFF_FFFF);
            end else begin
                rdata_from(last + 1, v);
            end
        end
        mark(S_BUSY, a0, last);
        mark(S_RD, last + 1, last + 1);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    // kind: 0 write, 1 read, 2 write+read in the same cycle.
    task automatic issue(input int kind, input bit en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws, input logic [AW-1:0] ra, input logic [DW-1:0] rv,
                         input int daw, input int dw, input int dar, input int dr,
                         output int s, output int lb);
        int e;
        bit ok;
        s = cyc;
        lb = s;
        sl_aw_d = daw; sl_w_d = dw; sl_ar_d = dar; sl_r_d = dr; sl_rdata = rv;
        bk_wstart = (kind != 1); bk_rstart = (kind != 0);
        bk_waddr = wa; bk_wdata = wd; bk_wstrb = ws; bk_raddr = ra; cc_enable = en;
        if (en) begin
            if (kind == 1) begin
                plan_read(s + 1, ra, rv, dar, dr, lb);
            end else begin
                plan_write(s, wa, wd, ws, daw, dw, e, ok);
                lb = e;
                if (kind == 2 && ok) plan_read(e + 1, ra, rv, dar, dr, lb);
            end
        end
        next_cyc();
        bk_wstart = 1'b0; bk_rstart = 1'b0;
    endtask

    // While busy, throw stray starts and toggle cc_enable; none of it may disturb the transaction.
    task automatic busy_wait(input int lb);
        while (cyc <= lb) begin
            bk_wstart = ($urandom_range(0, 3) == 0);
            bk_rstart = ($urandom_range(0, 3) == 0);
            bk_waddr = AW'($urandom); bk_raddr = AW'($urandom);
            bk_wdata = $urandom; bk_wstrb = SW'($urandom);
            cc_enable = ($urandom_range(0, 2) != 0);
            next_cyc();
        end
        bk_wstart = 1'b0; bk_rstart = 1'b0; cc_enable = 1'b1;
    endtask

    function automatic int rnd_delay();
        int x;
        x = int'($urandom_range(0, 15));
        if (x < 11) return x % 5;
        if (x < 13) return 7;
        if (x < 14) return 8;
        return 255;
    endfunction

    initial begin
        int s, lb;
        for (int c = 0; c < NCYC; c++) begin
            ex_rdata[c] = '0; ex_awaddr[c] = '0; ex_wdata[c] = '0; ex_wstrb[c] = '0; ex_araddr[c] = '0;
        end
        repeat (3) next_cyc();
        rst_n = 1'b1; cc_enable = 1'b1;
        repeat (2) next_cyc();

        // Write, slave always ready.
        issue(0, 1'b1, 15'h0100, 32'hDEADBEEF, 4'hF, '0, '0, 0, 0, 0, 0, s, lb);
        busy_wait(lb); repeat (2) next_cyc();
        chk("wr_latency", 32'(last_wdone - s), 32'd2);
        chk("wr_no_err", 32'(last_err > s), 32'd0);

        // Skewed readies.
        issue(0, 1'b1, 15'h0234, 32'hCAFE0001, 4'h5, '0, '0, 1, 4, 0, 0, s, lb);
        busy_wait(lb); repeat (2) next_cyc();
        chk("wr_skew_latency", 32'(last_wdone - s), 32'd6);

        // Read with delayed arready and rvalid.
        issue(1, 1'b1, '0, '0, '0, 15'h0040, 32'h12345678, 0, 0, 2, 3, s, lb);
        busy_wait(lb); repeat (2) next_cyc();
        chk("rd_latency", 32'(last_rdone - s), 32'd8);
        chk("rd_data", bk_rdata, 32'h12345678);
        chk("rd_busy_after", 32'(bk_busy), 32'd0);

        // Simultaneous write and read.
        issue(2, 1'b1, 15'h0008, 32'h0BADF00D, 4'h3, 15'h000C, 32'hA5A5_5A5A, 0, 0, 0, 0, s, lb);
        busy_wait(lb); repeat (2) next_cyc();
        chk("both_wdone", 32'(last_wdone - s), 32'd2);
        chk("both_rdone", 32'(last_rdone - s), 32'd4);

        // Read timeout: arready never comes.
        issue(1, 1'b1, '0, '0, '0, 15'h0044, 32'h1, 0, 0, 255, 0, s, lb);
        busy_wait(lb); repeat (2) next_cyc();
        chk("tmo_latency", 32'(last_rdone - s), 32'd9);
        chk("tmo_err", 32'(last_err - s), 32'd9);
        chk("tmo_rdata", bk_rdata, 32'hFFFF_FFFF);

        // Reset while wvalid is still pending.
        issue(0, 1'b1, 15'h0300, 32'h11112222, 4'hF, '0, '0, 0, 255, 0, 0, s, lb);
        repeat (2) next_cyc();
        for (int c = cyc; c < NCYC; c++) begin
            for (int k = 0; k < 8; k++) ex[k][c] = 1'b0;
            ex_rdata[c] = '0;
        end
        rst_n = 1'b0;
        repeat (2) next_cyc();
        rst_n = 1'b1;
        repeat (2) next_cyc();
        chk("rst_no_wdone", 32'(last_wdone >= s), 32'd0);

        // Disabled: request ignored.
        issue(2, 1'b0, 15'h0010, 32'h5, 4'h1, 15'h0014, 32'h6, 0, 0, 0, 0, s, lb);
        busy_wait(lb); repeat (3) next_cyc();

        for (int i = 0; i < 70 && cyc < NCYC - 80; i++) begin
            issue(int'($urandom_range(0, 2)), ($urandom_range(0, 7) != 0),
                  AW'($urandom), $urandom, SW'($urandom), AW'($urandom), $urandom,
                  rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay(), s, lb);
            busy_wait(lb);
            repeat ($urandom_range(0, 2)) next_cyc();
        end

        repeat (4) next_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
